// File: rtl/execute_cycle.sv
// Execute stage: ALU, branch resolution, flag register, iterative signed
// divider and the E-M pipeline register.
//
// Divider FSM states:
//   state  | meaning
//   IDLE   | no division running; a div/mod op here latches operands and stalls
//   BUSY   | one restoring-division step per cycle, 32 steps, stall held
//   DONE   | quotient/remainder ready; E-M register captures it, stall released
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_E,
    input  logic [31:0] branch_target_E,
    input  logic [31:0] a_E,
    input  logic [31:0] b_E,
    input  logic [31:0] rd2_E,
    input  logic [31:0] instruction_E,
    input  logic        isRet_E,
    input  logic        isSt_E,
    input  logic        isWb_E,
    input  logic        isBeq_E,
    input  logic        isBgt_E,
    input  logic        isUbranch_E,
    input  logic        isLd_E,
    input  logic        isCall_E,
    input  logic [4:0]  alusignals_E,
    input  logic [3:0]  RD_E,
    output logic [31:0] pc_M,
    output logic [31:0] aluresult_M,
    output logic [31:0] rd2_M,
    output logic [31:0] instruction_M,
    output logic        isSt_M,
    output logic        isLd_M,
    output logic        isWb_M,
    output logic        isCall_M,
    output logic [3:0]  RD_M,
    output logic        isBranchTaken,
    output logic [31:0] branchPC,
    output logic        stall
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_MUL = 5'd2;
    localparam logic [4:0] OP_DIV = 5'd3;
    localparam logic [4:0] OP_MOD = 5'd4;
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_OR  = 5'd7;
    localparam logic [4:0] OP_NOT = 5'd8;
    localparam logic [4:0] OP_MOV = 5'd9;
    localparam logic [4:0] OP_LSL = 5'd10;
    localparam logic [4:0] OP_LSR = 5'd11;
    localparam logic [4:0] OP_ASR = 5'd12;

    // divider state
    div_state_t  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        dz_q, dz_d;
    logic        is_mod_q, is_mod_d;

    // flags
    logic        flag_e_q, flag_e_d;
    logic        flag_gt_q, flag_gt_d;

    // E-M register
    logic [31:0] pc_m_q, pc_m_d;
    logic [31:0] alu_m_q, alu_m_d;
    logic [31:0] rd2_m_q, rd2_m_d;
    logic [31:0] instr_m_q, instr_m_d;
    logic        st_m_q, st_m_d;
    logic        ld_m_q, ld_m_d;
    logic        wb_m_q, wb_m_d;
    logic        call_m_q, call_m_d;
    logic [3:0]  rd_m_q, rd_m_d;

    logic        is_div_op;
    logic [4:0]  shamt;
    logic [31:0] alu_res;
    logic [32:0] rem_shift;
    logic [32:0] rem_diff;
    logic [31:0] quo_signed;
    logic [31:0] rem_signed;
    logic [31:0] div_res;

    assign is_div_op = (alusignals_E == OP_DIV) || (alusignals_E == OP_MOD);
    assign shamt     = b_E[4:0];

    // Branch resolution uses the flags as they stand at the start of the cycle.
    assign isBranchTaken = isUbranch_E | (isBeq_E & flag_e_q) | (isBgt_E & flag_gt_q);
    assign branchPC      = isRet_E ? a_E : branch_target_E;

    // Single-cycle ALU; div/mod/cmp and unused opcodes produce 0 here.
    always_comb begin
        alu_res = 32'd0;
        case (alusignals_E)
            OP_ADD: alu_res = a_E + b_E;
            OP_SUB: alu_res = a_E - b_E;
            OP_MUL: alu_res = a_E * b_E;
            OP_AND: alu_res = a_E & b_E;
            OP_OR:  alu_res = a_E | b_E;
            OP_NOT: alu_res = ~b_E;
            OP_MOV: alu_res = b_E;
            OP_LSL: alu_res = a_E << shamt;
            OP_LSR: alu_res = a_E >> shamt;
            OP_ASR: alu_res = $unsigned($signed(a_E) >>> shamt);
            default: alu_res = 32'd0;
        endcase
    end

    // Sign fix-up of the unsigned magnitudes; divide-by-zero forces all-ones quotient.
    always_comb begin
        quo_signed = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        rem_signed = neg_rem_q ? (32'd0 - rem_q) : rem_q;
        if (dz_q) begin
            quo_signed = 32'hFFFF_FFFF;
        end
        div_res = is_mod_q ? rem_signed : quo_signed;
    end

    // Divider FSM and restoring-division datapath; also produces stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        is_mod_d  = is_mod_q;
        stall     = 1'b0;
        rem_shift = {rem_q, quo_q[31]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        case (state_q)
            S_IDLE: begin
                if (is_div_op) begin
                    stall     = 1'b1;
                    quo_d     = a_E[31] ? (32'd0 - a_E) : a_E;
                    dvs_d     = b_E[31] ? (32'd0 - b_E) : b_E;
                    rem_d     = 32'd0;
                    neg_quo_d = a_E[31] ^ b_E[31];
                    neg_rem_d = a_E[31];
                    dz_d      = (b_E == 32'd0);
                    is_mod_d  = (alusignals_E == OP_MOD);
                    cnt_d     = 6'd32;
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (!rem_diff[32]) begin
                    rem_d = rem_diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // E-M register next value and flag update; a stall inserts a bubble.
    always_comb begin
        pc_m_d    = 32'd0;
        alu_m_d   = 32'd0;
        rd2_m_d   = 32'd0;
        instr_m_d = 32'd0;
        st_m_d    = 1'b0;
        ld_m_d    = 1'b0;
        wb_m_d    = 1'b0;
        call_m_d  = 1'b0;
        rd_m_d    = 4'd0;
        flag_e_d  = flag_e_q;
        flag_gt_d = flag_gt_q;
        if (!stall) begin
            pc_m_d    = pc_E;
            rd2_m_d   = rd2_E;
            instr_m_d = instruction_E;
            st_m_d    = isSt_E;
            ld_m_d    = isLd_E;
            wb_m_d    = isWb_E;
            call_m_d  = isCall_E;
            rd_m_d    = RD_E;
            if (isCall_E) begin
                alu_m_d = pc_E + 32'd4;
            end else if (state_q == S_DONE) begin
                alu_m_d = div_res;
            end else begin
                alu_m_d = alu_res;
            end
            if (alusignals_E == OP_CMP) begin
                flag_e_d  = (a_E == b_E);
                flag_gt_d = ($signed(a_E) > $signed(b_E));
            end
        end
    end

    // State, datapath, flag and E-M registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            dvs_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_mod_q  <= 1'b0;
            flag_e_q  <= 1'b0;
            flag_gt_q <= 1'b0;
            pc_m_q    <= 32'd0;
            alu_m_q   <= 32'd0;
            rd2_m_q   <= 32'd0;
            instr_m_q <= 32'd0;
            st_m_q    <= 1'b0;
            ld_m_q    <= 1'b0;
            wb_m_q    <= 1'b0;
            call_m_q  <= 1'b0;
            rd_m_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            is_mod_q  <= is_mod_d;
            flag_e_q  <= flag_e_d;
            flag_gt_q <= flag_gt_d;
            pc_m_q    <= pc_m_d;
            alu_m_q   <= alu_m_d;
            rd2_m_q   <= rd2_m_d;
            instr_m_q <= instr_m_d;
            st_m_q    <= st_m_d;
            ld_m_q    <= ld_m_d;
            wb_m_q    <= wb_m_d;
            call_m_q  <= call_m_d;
            rd_m_q    <= rd_m_d;
        end
    end

    assign pc_M          = pc_m_q;
    assign aluresult_M   = alu_m_q;
    assign rd2_M         = rd2_m_q;
    assign instruction_M = instr_m_q;
    assign isSt_M        = st_m_q;
    assign isLd_M        = ld_m_q;
    assign isWb_M        = wb_m_q;
    assign isCall_M      = call_m_q;
    assign RD_M          = rd_m_q;

endmodule

// File: doc/execute_cycle.md
EXECUTE_CYCLE -- requirements
Module: execute_cycle

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset; asserted (0) forces reset state immediately, independent of clk.
REQ-003 pc_E, branch_target_E, a_E, b_E, rd2_E, instruction_E  in  32 each  operands and instruction from the D-E register.
REQ-004 isRet_E, isSt_E, isWb_E, isBeq_E, isBgt_E, isUbranch_E, isLd_E, isCall_E  in  1 each  decoded controls.
REQ-005 alusignals_E  in  5  ALU opcode; RD_E  in  4  destination register.
REQ-006 pc_M, aluresult_M, rd2_M, instruction_M  out  32 each  registered E-M outputs.
REQ-007 isSt_M, isLd_M, isWb_M, isCall_M  out  1 each; RD_M  out  4  registered E-M outputs.
REQ-008 isBranchTaken  out  1; branchPC  out  32  combinational branch resolution for fetch redirect and flush.
REQ-009 stall  out  1  combinational; 1 = upstream holds the D-E register and PC unchanged.

Function
REQ-010 ALU opcodes: 0 add, 1 sub, 2 mul (low 32 bits), 3 div, 4 mod, 5 cmp, 6 and, 7 or, 8 not (~b), 9 mov (b), 10 lsl, 11 lsr, 12 asr; 13-31 yield result 0.
REQ-011 Add/sub wrap modulo 2^32; shift amount is b[4:0]; asr replicates a[31].
REQ-012 cmp: result 0; flags E = (a==b), GT = (signed a > signed b), captured at the clock edge when stall=0; flags hold otherwise.
REQ-013 When isCall_E=1, aluresult_M captures pc_E+4 instead of the ALU result.
REQ-014 isBranchTaken = isUbranch_E | (isBeq_E & flagE) | (isBgt_E & flagGT), using current flag register contents.
REQ-015 branchPC = a_E when isRet_E=1, else branch_target_E.
REQ-016 Non-div/mod ops: single cycle; E-M register captures results at the next edge.
REQ-017 Divider FSM states IDLE, BUSY, DONE; reset state IDLE.
REQ-018 IDLE with opcode 3 or 4: stall=1, latch |a|, |b| and signs, load 6-bit counter with 32, go to BUSY.
REQ-019 BUSY: one restoring-division step per cycle, counter decrements; stall=1; counter reaching 0 moves the FSM to DONE.
REQ-020 DONE: stall=0; E-M register captures the quotient (op 3) or remainder (op 4); the FSM goes to IDLE unconditionally, without re-arming on the held opcode.
REQ-021 Signed results: quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
REQ-022 Divide by zero: quotient 0xFFFFFFFF, remainder = a; same 34-cycle timing.
REQ-023 Total div/mod latency: 33 stall cycles, then result at the edge ending the DONE cycle.
REQ-024 While stall=1, the E-M register loads a bubble: all control outputs 0 and RD_M 0; data outputs 0.
REQ-025 Flags are never modified by div/mod.

Reset
REQ-026 rst=0: all E-M outputs 0, flagE=flagGT=0, FSM IDLE, counter 0, divider datapath 0.
REQ-027 Reset mid-division aborts the division; after release the FSM is in IDLE with stall=0 unless a div/mod op is presented.
REQ-028 isBranchTaken and branchPC follow inputs during reset, using the cleared flags.

Verification
REQ-029 add a=0xFFFFFFFF, b=2, isWb=1, RD=5 -> next edge: aluresult_M=1, isWb_M=1, RD_M=5.
REQ-030 cmp a=7, b=7, then beq with branch_target_E=0x40 -> isBranchTaken=1, branchPC=0x40; after cmp a=3, b=7, bgt -> isBranchTaken=0.
REQ-031 div a=-100, b=7 held -> stall=1 for 33 cycles, bubbles on the E-M register, then aluresult_M=0xFFFFFFF2 (-14); mod of the same operands -> 0xFFFFFFFE (-2).
REQ-032 div a=5, b=0 -> aluresult_M=0xFFFFFFFF after 34 cycles; mod -> 5.
REQ-033 call pc_E=0x100 -> aluresult_M=0x104, isCall_M=1; ret a_E=0x200 -> branchPC=0x200.
REQ-034 rst=0 asserted at BUSY cycle 10 -> outputs 0 immediately, stall=0 after release with a non-div op applied.
